// File: rtl/br_lite_local_if.sv
// BrLite PE-side local-port adapter.
// The TX side turns PE requests into router LOCAL-input flits.
// The RX side acks router LOCAL-output flits into a small FIFO that the PE drains.

package br_lite_pkg;
    localparam int BR_PAYLOAD_W = 32;
    localparam int BR_ADDR_W    = 16;
    localparam int BR_SVC_W     = 2;
    localparam int BR_ID_W      = 5;

    typedef enum logic [BR_SVC_W-1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_CLEAR = 2'd2
    } br_svc_t;

    // The field order sets the packed layout: payload sits in the MSBs and id in the LSBs.
    typedef struct packed {
        logic [BR_PAYLOAD_W-1:0] payload;
        logic [BR_ADDR_W-1:0]    seq_source;
        logic [BR_ADDR_W-1:0]    seq_target;
        br_svc_t                 service;
        logic [BR_ID_W-1:0]      id;
    } br_data_t;

    localparam int BR_DATA_W = $bits(br_data_t);
endpackage

module br_lite_local_if
    import br_lite_pkg::*;
#(
    parameter logic [BR_ADDR_W-1:0] SEQ_ADDRESS = 16'h0,
    parameter int                   RX_DEPTH    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    input  logic [BR_SVC_W-1:0]         tx_service_i,
    input  logic [BR_ADDR_W-1:0]        tx_target_i,
    input  logic [BR_PAYLOAD_W-1:0]     tx_payload_i,
    output logic                        tx_err_o,
    output logic [BR_DATA_W-1:0]        br_flit_o,
    output logic                        br_req_o,
    input  logic                        br_ack_i,
    input  logic                        br_busy_i,
    input  logic [BR_DATA_W-1:0]        br_flit_i,
    input  logic                        br_req_i,
    output logic                        br_ack_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [BR_DATA_W-1:0]        rx_data_o,
    output logic [$clog2(RX_DEPTH):0]   rx_count_o
);

    localparam int PTR_W   = $clog2(RX_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SVC_LSB = BR_ID_W;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_t;

    tx_state_t          state_q, state_d;
    logic [BR_ID_W-1:0] id_q;
    logic               tx_accept;
    logic               tx_legal;

    assign tx_accept = tx_valid_i && tx_ready_o;
    assign tx_legal  = br_svc_t'(tx_service_i) != BR_SVC_CLEAR;

    // TX next state and ready. Ready is only offered while idle, not in reset, and while the router is not busy.
    always_comb begin
        state_d    = state_q;
        tx_ready_o = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_ready_o = !br_busy_i && !rst_i;
                if (tx_valid_i && tx_ready_o && tx_legal) begin
                    state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                if (br_ack_i) begin
                    state_d = TX_GAP;
                end
            end
            TX_GAP:  state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TX flit, request, packet id and error pulse. The flit stays frozen until the next accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_req_o  <= 1'b0;
            br_flit_o <= '0;
            id_q      <= '0;
            tx_err_o  <= 1'b0;
        end else begin
            tx_err_o <= tx_accept && !tx_legal;
            if (tx_accept && tx_legal) begin
                br_flit_o <= {tx_payload_i, SEQ_ADDRESS, tx_target_i, tx_service_i, id_q};
                id_q      <= id_q + BR_ID_W'(1);
                br_req_o  <= 1'b1;
            end else if (state_q == TX_REQ && br_ack_i) begin
                br_req_o <= 1'b0;
            end
        end
    end

    logic [BR_DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 rx_full;
    logic                 rx_take;
    logic                 rx_push;
    logic                 rx_pop;

    // Full comes from the registered count. A pop therefore frees space for a take only on the following cycle.
    assign rx_full    = count_q == CNT_W'(RX_DEPTH);
    assign rx_take    = br_req_i && !br_ack_o && !rx_full;
    assign rx_push    = rx_take && (br_svc_t'(br_flit_i[SVC_LSB +: BR_SVC_W]) != BR_SVC_CLEAR);
    assign rx_valid_o = count_q != '0;
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign rx_count_o = count_q;
    assign rx_data_o  = rx_valid_o ? rx_mem[rd_ptr_q] : '0;

    // RX storage. Only the pointers are reset; an empty FIFO masks stale data.
    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem[wr_ptr_q] <= br_flit_i;
        end
    end

    // RX ack pulse, pointers and occupancy. The power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_ack_o <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            br_ack_o <= rx_take;
            if (rx_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_br_lite_local_if.sv
// Directed and randomized bench for br_lite_local_if, checked against a transaction-level model.
module tb_br_lite_local_if;
    import br_lite_pkg::*;

    localparam logic [BR_ADDR_W-1:0] SEQ    = 16'h1A5C;
    localparam int                   DEPTH  = 4;
    localparam int                   ID_MOD = 1 << BR_ID_W;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      tx_valid = 1'b0;
    logic                      tx_ready;
    logic [BR_SVC_W-1:0]       tx_service = '0;
    logic [BR_ADDR_W-1:0]      tx_target = '0;
    logic [BR_PAYLOAD_W-1:0]   tx_payload = '0;
    logic                      tx_err;
    logic [BR_DATA_W-1:0]      br_flit_out;
    logic                      br_req_out;
    logic                      br_ack_in = 1'b0;
    logic                      br_busy = 1'b0;
    logic [BR_DATA_W-1:0]      br_flit_in = '0;
    logic                      br_req_in = 1'b0;
    logic                      br_ack_out;
    logic                      rx_valid;
    logic                      rx_ready = 1'b0;
    logic [BR_DATA_W-1:0]      rx_data;
    logic [$clog2(DEPTH):0]    rx_count;

    int       checks = 0;
    int       failures = 0;
    int       model_id = 0;
    br_data_t rxq[$];

    br_lite_local_if #(.SEQ_ADDRESS(SEQ), .RX_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_service_i(tx_service),
        .tx_target_i(tx_target), .tx_payload_i(tx_payload), .tx_err_o(tx_err),
        .br_flit_o(br_flit_out), .br_req_o(br_req_out), .br_ack_i(br_ack_in),
        .br_busy_i(br_busy), .br_flit_i(br_flit_in), .br_req_i(br_req_in),
        .br_ack_o(br_ack_out), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .rx_data_o(rx_data), .rx_count_o(rx_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic br_data_t mk_tx_flit(logic [BR_PAYLOAD_W-1:0] pay, logic [BR_ADDR_W-1:0] tgt,
                                            logic [BR_SVC_W-1:0] svc, int id);
        br_data_t f;
        f.payload    = pay;
        f.seq_source = SEQ;
        f.seq_target = tgt;
        f.service    = br_svc_t'(svc);
        f.id         = BR_ID_W'(id);
        return f;
    endfunction

    function automatic br_data_t rnd_rx_flit(bit allow_clear);
        br_data_t f;
        f.payload    = $urandom;
        f.seq_source = BR_ADDR_W'($urandom);
        f.seq_target = BR_ADDR_W'($urandom);
        f.service    = br_svc_t'(allow_clear ? $urandom_range(0, 2) : $urandom_range(0, 1));
        f.id         = BR_ID_W'($urandom);
        return f;
    endfunction

    // The PE issues one request; the bench then plays the router, acking after `delay` cycles of req.
    task automatic send_tx(input logic [BR_SVC_W-1:0] svc, input logic [BR_ADDR_W-1:0] tgt,
                           input logic [BR_PAYLOAD_W-1:0] pay, input int delay);
        br_data_t e;
        tx_service = svc;
        tx_target  = tgt;
        tx_payload = pay;
        tx_valid   = 1'b1;
        br_busy    = 1'b0;
        #1;
        chk("tx_ready_idle", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        if (br_svc_t'(svc) == BR_SVC_CLEAR) begin
            chk("tx_err_pulse", tx_err, 1'b1);
            chk("tx_clear_no_req", br_req_out, 1'b0);
            tick();
            chk("tx_err_end", tx_err, 1'b0);
            chk("tx_clear_no_req2", br_req_out, 1'b0);
        end else begin
            e = mk_tx_flit(pay, tgt, svc, model_id);
            model_id = (model_id + 1) % ID_MOD;
            chk("tx_req_rise", br_req_out, 1'b1);
            chk("tx_flit", br_flit_out, e);
            chk("tx_no_err", tx_err, 1'b0);
            for (int i = 1; i < delay; i++) begin
                tick();
                chk("tx_req_hold", br_req_out, 1'b1);
                chk("tx_flit_stable", br_flit_out, e);
                chk("tx_ready_busy", tx_ready, 1'b0);
            end
            br_ack_in = 1'b1;
            tick();
            br_ack_in = 1'b0;
            chk("tx_req_drop", br_req_out, 1'b0);
            chk("tx_ready_gap", tx_ready, 1'b0);
            tick();
            chk("tx_ready_after_gap", tx_ready, 1'b1);
        end
    endtask

    // The router offers one flit and holds req until it is acked or the bound expires.
    task automatic offer(input br_data_t f);
        bit acked;
        acked      = 1'b0;
        br_req_in  = 1'b1;
        br_flit_in = f;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (br_ack_out) acked = 1'b1;
        end
        br_req_in = 1'b0;
        chk("rx_acked", acked, 1'b1);
        if (acked && f.service != BR_SVC_CLEAR) rxq.push_back(f);
        chk("rx_count_after_take", rx_count, rxq.size());
        tick();
        chk("rx_ack_pulse_end", br_ack_out, 1'b0);
    endtask

    task automatic pop_one();
        chk("rx_valid_head", rx_valid, 1'b1);
        chk("rx_head_data", rx_data, rxq[0]);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        void'(rxq.pop_front());
        chk("rx_count_after_pop", rx_count, rxq.size());
    endtask

    initial begin
        br_data_t held;
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req", br_req_out, 1'b0);
        chk("rst_flit", br_flit_out, '0);
        chk("rst_err", tx_err, 1'b0);
        chk("rst_ack", br_ack_out, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_count", rx_count, 0);

        // A broadcast request, acked after three cycles, followed by a second request with the next id
        send_tx(BR_SVC_ALL, 16'd5, 32'hAB, 3);
        send_tx(BR_SVC_TGT, BR_ADDR_W'($urandom), $urandom, $urandom_range(1, 4));

        // A busy router holds off acceptance
        br_busy  = 1'b1;
        tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("busy_ready_low", tx_ready, 1'b0);
            chk("busy_no_req", br_req_out, 1'b0);
        end
        send_tx(BR_SVC_ALL, BR_ADDR_W'($urandom), $urandom, 2);

        // An illegal service is dropped and does not consume an id
        send_tx(BR_SVC_CLEAR, 16'd9, 32'h1, 1);
        send_tx(BR_SVC_TGT, 16'd7, $urandom, 1);

        // Back-pressure from a full RX FIFO, then release by a single pop
        for (int i = 0; i < DEPTH; i++) offer(rnd_rx_flit(1'b0));
        chk("rx_full_count", rx_count, DEPTH);
        held       = rnd_rx_flit(1'b0);
        br_req_in  = 1'b1;
        br_flit_in = held;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rx_full_no_ack", br_ack_out, 1'b0);
        end
        pop_one();
        chk("rx_ack_not_yet", br_ack_out, 1'b0);
        tick();
        chk("rx_ack_after_pop", br_ack_out, 1'b1);
        br_req_in = 1'b0;
        rxq.push_back(held);
        chk("rx_refill_count", rx_count, DEPTH);
        while (rxq.size() > 0) pop_one();
        chk("rx_empty_valid", rx_valid, 1'b0);

        // A CLEAR flit is acked but never stored
        held = rnd_rx_flit(1'b0);
        held.service = BR_SVC_CLEAR;
        offer(held);
        chk("rx_clear_discard", rx_count, 0);

        // Random RX traffic interleaved with pops
        for (int n = 0; n < 30; n++) begin
            if (($urandom_range(0, 1) == 1 && rxq.size() < DEPTH) || rxq.size() == 0)
                offer(rnd_rx_flit(1'b1));
            else
                pop_one();
        end
        while (rxq.size() > 0) pop_one();

        // The packet id wraps from all-ones back to zero
        while (model_id != ID_MOD - 1)
            send_tx(2'($urandom_range(0, 1)), BR_ADDR_W'($urandom), $urandom, $urandom_range(1, 3));
        send_tx(BR_SVC_ALL, 16'd3, $urandom, 1);
        chk("id_wrapped_model", model_id, 0);
        send_tx(BR_SVC_TGT, 16'd4, $urandom, 2);

        // Reset while a TX request is pending and the RX FIFO holds two flits
        offer(rnd_rx_flit(1'b0));
        offer(rnd_rx_flit(1'b0));
        tx_service = BR_SVC_ALL;
        tx_valid   = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("pre_rst_req", br_req_out, 1'b1);
        chk("pre_rst_count", rx_count, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", br_req_out, 1'b0);
        chk("mid_rst_count", rx_count, 0);
        chk("mid_rst_valid", rx_valid, 1'b0);
        chk("mid_rst_flit", br_flit_out, '0);
        rst = 1'b0;
        rxq.delete();
        model_id = 0;
        tick();
        send_tx(BR_SVC_TGT, 16'd11, $urandom, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
